// File: rtl/reg_writeback_ctrl.sv
// Write-back controller: in-order write queue feeding
// the two register file write ports, with pending-write checks.
module reg_writeback_ctrl #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in0_valid,
  input  logic [ADDR_W-1:0]        in0_dst,
  input  logic [DATA_W-1:0]        in0_data,
  input  logic                     in1_valid,
  input  logic [ADDR_W-1:0]        in1_dst,
  input  logic [DATA_W-1:0]        in1_data,
  output logic                     in_ready,
  output logic                     regWrite,
  output logic [ADDR_W-1:0]        regDst1,
  output logic [DATA_W-1:0]        bus_w,
  output logic                     regWrite2,
  output logic [ADDR_W-1:0]        regDst2,
  output logic [DATA_W-1:0]        bus2_w,
  input  logic [ADDR_W-1:0]        chk_src1,
  input  logic [ADDR_W-1:0]        chk_src2,
  output logic                     chk_busy1,
  output logic                     chk_busy2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [ADDR_W-1:0] dstMem  [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];

  ptr_t             head;
  ptr_t             tail;
  ptr_t             head1;
  ptr_t             slot1;
  ptr_t             off [DEPTH];
  logic [DEPTH-1:0] live;
  cnt_t             enqCnt;
  cnt_t             deqCnt;
  logic             accept;
  logic             hasOne;
  logic             hasTwo;
  logic             pairOk;

  assign head1  = head + ptr_t'(1);
  assign hasOne = (count != '0);
  assign hasTwo = (count >= cnt_t'(2));
  // Same-destination pairs go out one per cycle to keep order.
  assign pairOk = hasTwo && (dstMem[head1] != dstMem[head]);

  // Conservative: based on registered occupancy only.
  assign in_ready = (count <= cnt_t'(DEPTH - 2));
  assign accept   = in_ready && !flush;
  assign slot1    = in0_valid ? (tail + ptr_t'(1)) : tail;

  assign enqCnt = accept
                ? (cnt_t'(in0_valid) + cnt_t'(in1_valid))
                : '0;

  assign deqCnt = flush  ? cnt_t'(0) :
                  pairOk ? cnt_t'(2) :
                  hasOne ? cnt_t'(1) :
                           cnt_t'(0);

  // Write ports are driven from queue state only.
  always_comb begin
    regWrite  = hasOne && !flush;
    regDst1   = dstMem[head];
    bus_w     = dataMem[head];
    regWrite2 = pairOk && !flush;
    regDst2   = dstMem[head1];
    bus2_w    = dataMem[head1];
  end

  // Mark which slots hold queued writes (offset from head < count).
  always_comb begin
    live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off[i]  = ptr_t'(i) - head;
      live[i] = ({1'b0, off[i]} < count);
    end
  end

  // Pending-write lookup over every queued entry.
  always_comb begin
    chk_busy1 = 1'b0;
    chk_busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && dstMem[i] == chk_src1) chk_busy1 = 1'b1;
      if (live[i] && dstMem[i] == chk_src2) chk_busy2 = 1'b1;
    end
    if (flush) begin
      chk_busy1 = 1'b0;
      chk_busy2 = 1'b0;
    end
  end

  // Pointer and occupancy update; flush empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ptr_t'(deqCnt);
      tail  <= tail + ptr_t'(enqCnt);
      count <= count + enqCnt - deqCnt;
    end
  end

  // Entry storage; older request lands at tail.
  always_ff @(posedge clk) begin
    if (accept && in0_valid) begin
      dstMem[tail]  <= in0_dst;
      dataMem[tail] <= in0_data;
    end
    if (accept && in1_valid) begin
      dstMem[slot1]  <= in1_dst;
      dataMem[slot1] <= in1_data;
    end
  end

`ifndef SYNTHESIS
  // Occupancy can never pass the queue depth.
  a_noOverflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    count <= cnt_t'(DEPTH)
  );
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: queue-based model
// checked every cycle plus directed literal checks.
module tb_reg_writeback_ctrl;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in0_valid = 1'b0;
  logic [ADDR_W-1:0] in0_dst = '0;
  logic [DATA_W-1:0] in0_data = '0;
  logic              in1_valid = 1'b0;
  logic [ADDR_W-1:0] in1_dst = '0;
  logic [DATA_W-1:0] in1_data = '0;
  logic              in_ready;
  logic              regWrite;
  logic [ADDR_W-1:0] regDst1;
  logic [DATA_W-1:0] bus_w;
  logic              regWrite2;
  logic [ADDR_W-1:0] regDst2;
  logic [DATA_W-1:0] bus2_w;
  logic [ADDR_W-1:0] chk_src1 = '0;
  logic [ADDR_W-1:0] chk_src2 = '0;
  logic              chk_busy1;
  logic              chk_busy2;
  logic [CW-1:0]     count;

  int total = 0;
  int bad = 0;
  bit chkOn = 1'b0;

  always #5 clk = ~clk;

  reg_writeback_ctrl #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in0_valid(in0_valid), .in0_dst(in0_dst),
    .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_dst(in1_dst),
    .in1_data(in1_data),
    .in_ready(in_ready),
    .regWrite(regWrite), .regDst1(regDst1), .bus_w(bus_w),
    .regWrite2(regWrite2), .regDst2(regDst2),
    .bus2_w(bus2_w),
    .chk_src1(chk_src1), .chk_src2(chk_src2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .count(count)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic pair(input logic [3:0] d0, input logic [31:0] v0,
                      input logic [3:0] d1, input logic [31:0] v1);
    in0_valid = 1'b1; in0_dst = d0; in0_data = v0;
    in1_valid = 1'b1; in1_dst = d1; in1_data = v1;
  endtask

  // Model: plain list of pending writes, oldest first.
  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t q[$];
  int   mn;
  bit   mOk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      mn  = q.size();
      mOk = (DEPTH - mn) >= 2;
      if (mn >= 2 && q[1].dst != q[0].dst) begin
        void'(q.pop_front());
        void'(q.pop_front());
      end else if (mn >= 1) begin
        void'(q.pop_front());
      end
      if (mOk && in0_valid) q.push_back({in0_dst, in0_data});
      if (mOk && in1_valid) q.push_back({in1_dst, in1_data});
    end
  end

  int cn;
  bit cw1, cw2, cb1, cb2;

  // Compare process: mid-cycle, every cycle out of reset.
  always @(negedge clk) begin
    if (chkOn && rst_n) begin
      cn  = q.size();
      cw1 = !flush && cn >= 1;
      cw2 = !flush && cn >= 2 && q[1].dst != q[0].dst;
      cb1 = 1'b0;
      cb2 = 1'b0;
      foreach (q[i]) begin
        if (q[i].dst == chk_src1) cb1 = 1'b1;
        if (q[i].dst == chk_src2) cb2 = 1'b1;
      end
      if (flush) begin
        cb1 = 1'b0;
        cb2 = 1'b0;
      end
      chk("m.count", 32'(count), 32'(cn));
      chk("m.in_ready", 32'(in_ready), 32'(cn <= DEPTH - 2));
      chk("m.regWrite", 32'(regWrite), 32'(cw1));
      chk("m.regWrite2", 32'(regWrite2), 32'(cw2));
      chk("m.busy1", 32'(chk_busy1), 32'(cb1));
      chk("m.busy2", 32'(chk_busy2), 32'(cb2));
      if (cw1) begin
        chk("m.dst1", 32'(regDst1), 32'(q[0].dst));
        chk("m.data1", bus_w, q[0].data);
      end
      if (cw2) begin
        chk("m.dst2", 32'(regDst2), 32'(q[1].dst));
        chk("m.data2", bus2_w, q[1].data);
      end
    end
  end

  initial begin
    #1;
    chk("rst.count", 32'(count), 0);
    chk("rst.ready", 32'(in_ready), 1);
    chk("rst.we", 32'(regWrite), 0);
    chk("rst.we2", 32'(regWrite2), 0);
    chk("rst.busy", 32'(chk_busy1), 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    chkOn = 1'b1;

    // single write
    @(posedge clk); #1;
    in0_valid = 1'b1; in0_dst = 4'd5;
    in0_data = 32'hDEADBEEF; chk_src1 = 4'd5;
    @(negedge clk);
    chk("t1.pre_busy", 32'(chk_busy1), 0);
    @(posedge clk); #1; idle();
    @(negedge clk);
    chk("t1.we", 32'(regWrite), 1);
    chk("t1.dst", 32'(regDst1), 5);
    chk("t1.data", bus_w, 32'hDEADBEEF);
    chk("t1.we2", 32'(regWrite2), 0);
    chk("t1.busy", 32'(chk_busy1), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1.count", 32'(count), 0);
    chk("t1.busy_clr", 32'(chk_busy1), 0);

    // dual write, distinct destinations
    @(posedge clk); #1;
    pair(4'd2, 32'h11, 4'd3, 32'h22);
    chk_src1 = 4'd2; chk_src2 = 4'd3;
    @(posedge clk); #1; idle();
    @(negedge clk);
    chk("t2.we", 32'(regWrite), 1);
    chk("t2.we2", 32'(regWrite2), 1);
    chk("t2.dst1", 32'(regDst1), 2);
    chk("t2.data1", bus_w, 32'h11);
    chk("t2.dst2", 32'(regDst2), 3);
    chk("t2.data2", bus2_w, 32'h22);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2.count", 32'(count), 0);

    // same destination serialises
    @(posedge clk); #1;
    pair(4'd7, 32'hA, 4'd7, 32'hB);
    chk_src1 = 4'd7;
    @(posedge clk); #1; idle();
    @(negedge clk);
    chk("t3.c1_we2", 32'(regWrite2), 0);
    chk("t3.c1_data", bus_w, 32'hA);
    chk("t3.c1_busy", 32'(chk_busy1), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3.c2_dst", 32'(regDst1), 7);
    chk("t3.c2_data", bus_w, 32'hB);
    chk("t3.c2_busy", 32'(chk_busy1), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3.busy_clr", 32'(chk_busy1), 0);

    // backpressure: same-dst pair every cycle
    chk_src1 = 4'd1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      pair(4'd1, 32'(256 + 2 * k), 4'd1, 32'(257 + 2 * k));
      @(negedge clk);
      if (k > 0) begin
        chk("t4.count", 32'(count), (k % 2) ? 2 : 3);
        chk("t4.ready", 32'(in_ready), (k % 2) ? 1 : 0);
      end
    end
    @(posedge clk); #1; idle();
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t4.drained", 32'(count), 0);

    // flush with three queued
    @(posedge clk); #1;
    pair(4'd8, 32'h80, 4'd8, 32'h81);
    @(posedge clk); #1;
    pair(4'd9, 32'h90, 4'd9, 32'h91);
    @(posedge clk); #1;
    idle();
    flush = 1'b1; in0_valid = 1'b1; in0_dst = 4'd8;
    chk_src1 = 4'd8; chk_src2 = 4'd9;
    @(negedge clk);
    chk("t5.count", 32'(count), 3);
    chk("t5.we", 32'(regWrite), 0);
    chk("t5.we2", 32'(regWrite2), 0);
    chk("t5.busy1", 32'(chk_busy1), 0);
    chk("t5.busy2", 32'(chk_busy2), 0);
    @(posedge clk); #1; idle();
    @(negedge clk);
    chk("t5.count_after", 32'(count), 0);
    chk("t5.we_after", 32'(regWrite), 0);
    chk("t5.busy_after", 32'(chk_busy1), 0);

    // async reset mid-cycle
    @(posedge clk); #1;
    pair(4'd10, 32'hA0, 4'd10, 32'hA1);
    chk_src1 = 4'd10;
    @(posedge clk); #1;
    pair(4'd11, 32'hB0, 4'd11, 32'hB1);
    @(posedge clk); #1; idle();
    @(negedge clk);
    chk("t6.pre_we", 32'(regWrite), 1);
    chk("t6.pre_busy", 32'(chk_busy1), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6.we", 32'(regWrite), 0);
    chk("t6.we2", 32'(regWrite2), 0);
    chk("t6.busy", 32'(chk_busy1), 0);
    chk("t6.count", 32'(count), 0);
    chk("t6.ready", 32'(in_ready), 1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6.count_rel", 32'(count), 0);
    chk("t6.ready_rel", 32'(in_ready), 1);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
